// File: rtl/n2_tlb_param_cam.sv
// Parameterized fully-associative TLB CAM: lookup, indexed/replacement writes, read,
// page/context demaps and a multi-cycle demap-all sweep (8 entries per cycle).

module n2_tlb_cam_entry #(
    parameter int KEY_W = 66,
    parameter int CTX_W = 13
) (
    input  logic             valid,
    input  logic [KEY_W-1:0] tag,
    input  logic [KEY_W-1:0] key,
    output logic             page_hit,
    output logic             ctx_hit
);
    assign page_hit = valid && (tag == key);
    assign ctx_hit  = valid && (tag[CTX_W-1:0] == key[CTX_W-1:0]);
endmodule

module n2_tlb_param_cam #(
    parameter  int ENTRIES = 64,
    parameter  int KEY_W   = 66,
    parameter  int CTX_W   = 13,
    parameter  int DATA_W  = 38,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              l2clk,
    input  logic              rst_l,
    input  logic              op_vld,
    input  logic [2:0]        op,
    input  logic [IDX_W-1:0]  op_idx,
    input  logic [KEY_W-1:0]  op_key,
    input  logic [DATA_W-1:0] op_data,
    output logic              op_rdy,
    output logic              rsp_vld,
    output logic              rsp_hit,
    output logic              rsp_mhit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [KEY_W-1:0]  rsp_key,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_valid_bit,
    output logic              full
);
    localparam int NGRP  = ENTRIES / 8;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    localparam logic [2:0] OP_LKP = 3'd0, OP_WRI = 3'd1, OP_WRR = 3'd2, OP_RD = 3'd3,
                           OP_DPG = 3'd4, OP_DCX = 3'd5, OP_DALL = 3'd6;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                         state_q, state_d;
    logic [GRP_W-1:0]               grp_q, grp_d;
    logic [ENTRIES-1:0]             valid_q, valid_d, used_q, used_d;
    logic [ENTRIES-1:0][KEY_W-1:0]  tag_q;
    logic [ENTRIES-1:0][DATA_W-1:0] data_q;
    logic [ENTRIES-1:0]             page_hit, ctx_hit, wr_mask, set_mask, sweep_mask;
    logic [IDX_W-1:0]               lkp_idx, inv_idx, old_idx, victim, wr_idx;
    logic                           accept, is_lkp, is_wr, is_wrr, is_rd, mhit;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        n2_tlb_cam_entry #(.KEY_W(KEY_W), .CTX_W(CTX_W)) u_ent (
            .valid    (valid_q[g]),
            .tag      (tag_q[g]),
            .key      (op_key),
            .page_hit (page_hit[g]),
            .ctx_hit  (ctx_hit[g])
        );
    end

    assign op_rdy = (state_q == IDLE);
    assign accept = op_vld && op_rdy;
    assign is_lkp = accept && (op == OP_LKP);
    assign is_wrr = accept && (op == OP_WRR);
    assign is_wr  = accept && ((op == OP_WRI) || (op == OP_WRR));
    assign is_rd  = accept && (op == OP_RD);
    assign full   = &valid_q;
    // Two or more hits: clearing the lowest set bit leaves something behind.
    assign mhit   = |(page_hit & (page_hit - ENTRIES'(1)));
    assign wr_idx = is_wrr ? victim : op_idx;

    always_comb begin
        lkp_idx = '0;
        inv_idx = '0;
        old_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (page_hit[i]) lkp_idx = IDX_W'(i);
            if (!valid_q[i]) inv_idx = IDX_W'(i);
            if (!used_q[i])  old_idx = IDX_W'(i);
        end
        victim = full ? old_idx : inv_idx;
    end

    always_comb begin
        wr_mask    = '0;
        sweep_mask = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            wr_mask[i]    = is_wr && (wr_idx == IDX_W'(i));
            sweep_mask[i] = (GRP_W'(i / 8) == grp_q);
        end
        set_mask = is_lkp ? page_hit : wr_mask;
    end

    always_comb begin
        valid_d = valid_q;
        used_d  = used_q;
        if (state_q == SWEEP) begin
            valid_d = valid_q & ~sweep_mask;
            used_d  = used_q & ~sweep_mask;
        end else if (accept) begin
            valid_d = valid_q | wr_mask;
            if (op == OP_DPG) valid_d = valid_d & ~page_hit;
            if (op == OP_DCX) valid_d = valid_d & ~ctx_hit;
            // Pseudo-LRU: when every valid entry would be used, keep only the fresh ones.
            if (|set_mask)
                used_d = ((valid_d & ~(used_q | set_mask)) == '0) ? set_mask
                                                                   : (used_q | set_mask);
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        case (state_q)
            IDLE: if (accept && op == OP_DALL) begin
                state_d = SWEEP;
                grp_d   = '0;
            end
            SWEEP: begin
                grp_d = grp_q + GRP_W'(1);
                if (grp_q == GRP_W'(NGRP - 1)) begin
                    state_d = IDLE;
                    grp_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            grp_q   <= '0;
            valid_q <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            valid_q <= valid_d;
            used_q  <= used_d;
        end
    end

    // Tag/data storage carries no reset; entries are qualified by valid_q.
    always_ff @(posedge l2clk) begin
        if (is_wr) begin
            tag_q[wr_idx]  <= op_key;
            data_q[wr_idx] <= op_data;
        end
    end

    always_ff @(posedge l2clk or negedge rst_l) begin
        if (!rst_l) begin
            rsp_vld       <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_mhit      <= 1'b0;
            rsp_idx       <= '0;
            rsp_key       <= '0;
            rsp_data      <= '0;
            rsp_valid_bit <= 1'b0;
        end else begin
            rsp_vld <= accept && !op[2];
            if (accept && !op[2]) begin
                rsp_hit       <= is_lkp && (|page_hit);
                rsp_mhit      <= is_lkp && mhit;
                rsp_idx       <= is_lkp ? lkp_idx : wr_idx;
                rsp_data      <= (is_lkp && (|page_hit)) ? data_q[lkp_idx] :
                                 is_rd ? data_q[op_idx] : '0;
                rsp_key       <= is_rd ? tag_q[op_idx] : '0;
                rsp_valid_bit <= is_rd && valid_q[op_idx];
            end
        end
    end
endmodule

// File: tb/tb_n2_tlb_param_cam.sv
// Bench for n2_tlb_param_cam: vector table plus fill, demap-all and mid-sweep reset sequences,
// with responses checked against a queue of expected results.
`timescale 1ns/1ps
module tb_n2_tlb_param_cam;
    localparam int ENTRIES = 64, KEY_W = 66, CTX_W = 13, DATA_W = 38, IDX_W = 6;
    localparam int K_NONE = 0, K_LK = 1, K_WR = 2, K_RD = 3;
    localparam logic [2:0] OP_LKP = 3'd0, OP_WRI = 3'd1, OP_WRR = 3'd2, OP_RD = 3'd3,
                           OP_DPG = 3'd4, OP_DCX = 3'd5, OP_DALL = 3'd6, OP_RSV = 3'd7;

    typedef struct {
        int                kind;
        logic              hit;
        logic              mhit;
        logic [IDX_W-1:0]  idx;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
        logic              vb;
    } exp_t;

    typedef struct {
        logic [2:0]        op;
        logic [IDX_W-1:0]  idx;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
        exp_t              ex;
    } vec_t;

    logic              l2clk, rst_l, op_vld;
    logic [2:0]        op;
    logic [IDX_W-1:0]  op_idx;
    logic [KEY_W-1:0]  op_key;
    logic [DATA_W-1:0] op_data;
    logic              op_rdy, rsp_vld, rsp_hit, rsp_mhit, rsp_valid_bit, full;
    logic [IDX_W-1:0]  rsp_idx;
    logic [KEY_W-1:0]  rsp_key;
    logic [DATA_W-1:0] rsp_data;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   passed = 0, total = 0;

    n2_tlb_param_cam #(.ENTRIES(ENTRIES), .KEY_W(KEY_W), .CTX_W(CTX_W), .DATA_W(DATA_W)) dut (
        .l2clk(l2clk), .rst_l(rst_l), .op_vld(op_vld), .op(op), .op_idx(op_idx),
        .op_key(op_key), .op_data(op_data), .op_rdy(op_rdy), .rsp_vld(rsp_vld),
        .rsp_hit(rsp_hit), .rsp_mhit(rsp_mhit), .rsp_idx(rsp_idx), .rsp_key(rsp_key),
        .rsp_data(rsp_data), .rsp_valid_bit(rsp_valid_bit), .full(full)
    );

    always #5 l2clk = ~l2clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    function automatic exp_t mk(input int k, input logic h, input logic m, input logic [IDX_W-1:0] i,
                                input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] d, input logic v);
        exp_t e;
        e.kind = k; e.hit = h; e.mhit = m; e.idx = i; e.key = key; e.data = d; e.vb = v;
        return e;
    endfunction
    function automatic exp_t lk(input logic h, input logic m, input logic [IDX_W-1:0] i,
                                input logic [DATA_W-1:0] d);
        return mk(K_LK, h, m, i, '0, d, 1'b0);
    endfunction
    function automatic exp_t wr(input logic [IDX_W-1:0] i);
        return mk(K_WR, 1'b0, 1'b0, i, '0, '0, 1'b0);
    endfunction
    function automatic exp_t rd(input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d, input logic v);
        return mk(K_RD, 1'b0, 1'b0, '0, k, d, v);
    endfunction
    function automatic exp_t nr();
        return mk(K_NONE, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endfunction
    function automatic vec_t mv(input logic [2:0] o, input logic [IDX_W-1:0] i,
                                input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d, input exp_t e);
        vec_t v;
        v.op = o; v.idx = i; v.key = k; v.data = d; v.ex = e;
        return v;
    endfunction
    function automatic logic [KEY_W-1:0] fk(input int i);
        return {34'h2_0000_0000, 32'(i)};
    endfunction

    exp_t me;
    always @(negedge l2clk) begin
        if (rst_l && rsp_vld) begin
            if (exp_q.size() == 0) chk("rsp_vld_unexpected", rsp_vld, 1'b0);
            else begin
                me = exp_q.pop_front();
                case (me.kind)
                    K_LK: begin
                        chk("lk_hit", rsp_hit, me.hit);
                        chk("lk_mhit", rsp_mhit, me.mhit);
                        chk("lk_idx", rsp_idx, me.idx);
                        chk("lk_data", rsp_data, me.data);
                    end
                    K_WR: chk("wr_idx", rsp_idx, me.idx);
                    default: begin
                        chk("rd_key", rsp_key, me.key);
                        chk("rd_data", rsp_data, me.data);
                        chk("rd_vbit", rsp_valid_bit, me.vb);
                    end
                endcase
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [IDX_W-1:0] i, input logic [KEY_W-1:0] k,
                         input logic [DATA_W-1:0] d, input exp_t e);
        op_vld = 1'b1; op = o; op_idx = i; op_key = k; op_data = d;
        if (e.kind != K_NONE) exp_q.push_back(e);
        @(posedge l2clk); #1;
        op_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge l2clk); #1; end
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        idle(2);
        rst_l = 1'b1;
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [KEY_W-1:0]  K1 = 66'h1_2345_6789_ABCD_1005, K2 = 66'h2_0000_0000_0000_0ABC,
                                  K3 = 66'h0_DEAD_BEEF_0000_0777, CA = 66'h0_0000_0000_1111_0001,
                                  CB = 66'h0_0000_0000_2222_0001, CC = 66'h0_0000_0000_1111_0002,
                                  DC = 66'h3_FFFF_FFFF_FFFF_E001;
    localparam logic [DATA_W-1:0] D1 = 38'h12_3456_789A, D2 = 38'h00_0000_BEEF, D3 = 38'h3F_0000_0001;

    initial begin
        int n;
        l2clk = 0; rst_l = 0; op_vld = 0; op = '0; op_idx = '0; op_key = '0; op_data = '0;

        vecs.push_back(mv(OP_WRI, 6'd5, K1, D1, wr(6'd5)));
        vecs.push_back(mv(OP_LKP, 6'd0, K1, '0, lk(1, 0, 6'd5, D1)));
        vecs.push_back(mv(OP_WRI, 6'd3, K2, D2, wr(6'd3)));
        vecs.push_back(mv(OP_WRI, 6'd9, K2, D3, wr(6'd9)));
        vecs.push_back(mv(OP_LKP, 6'd0, K2, '0, lk(1, 1, 6'd3, D2)));
        vecs.push_back(mv(OP_RD,  6'd9, '0, '0, rd(K2, D3, 1)));
        vecs.push_back(mv(OP_DPG, 6'd0, K1, '0, nr()));
        vecs.push_back(mv(OP_LKP, 6'd0, K1, '0, lk(0, 0, 6'd0, '0)));
        vecs.push_back(mv(OP_RD,  6'd5, '0, '0, rd(K1, D1, 0)));
        vecs.push_back(mv(OP_WRI, 6'd0, CA, 38'd1, wr(6'd0)));
        vecs.push_back(mv(OP_WRI, 6'd2, CB, 38'd2, wr(6'd2)));
        vecs.push_back(mv(OP_WRI, 6'd1, CC, 38'd3, wr(6'd1)));
        vecs.push_back(mv(OP_DCX, 6'd0, DC, '0, nr()));
        vecs.push_back(mv(OP_LKP, 6'd0, CA, '0, lk(0, 0, 6'd0, '0)));
        vecs.push_back(mv(OP_LKP, 6'd0, CB, '0, lk(0, 0, 6'd0, '0)));
        vecs.push_back(mv(OP_LKP, 6'd0, CC, '0, lk(1, 0, 6'd1, 38'd3)));
        vecs.push_back(mv(OP_RSV, 6'd4, K2, D1, nr()));
        vecs.push_back(mv(OP_LKP, 6'd0, K2, '0, lk(1, 1, 6'd3, D2)));
        vecs.push_back(mv(OP_WRR, 6'd0, K3, D1, wr(6'd0)));
        vecs.push_back(mv(OP_LKP, 6'd0, K3, '0, lk(1, 0, 6'd0, D1)));
        vecs.push_back(mv(OP_RD,  6'd1, '0, '0, rd(CC, 38'd3, 1)));

        @(posedge l2clk); #1;
        chk("rst_op_rdy", op_rdy, 1'b1);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_rsp_hit", rsp_hit, 1'b0);
        chk("rst_rsp_idx", rsp_idx, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_full", full, 1'b0);
        idle(1);
        rst_l = 1'b1;
        idle(1);

        foreach (vecs[v]) issue(vecs[v].op, vecs[v].idx, vecs[v].key, vecs[v].data, vecs[v].ex);
        idle(2);
        chk("drain_table", exp_q.size(), 0);

        // Replacement fill from empty, then pseudo-LRU victims.
        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            if (i == ENTRIES - 1) chk("full_before_last", full, 1'b0);
            issue(OP_WRR, '0, fk(i), DATA_W'(i), wr(IDX_W'(i)));
        end
        chk("full_after_fill", full, 1'b1);
        issue(OP_WRR, '0, fk(100), 38'd100, wr(6'd0));
        issue(OP_WRR, '0, fk(101), 38'd101, wr(6'd1));
        issue(OP_LKP, '0, fk(0), '0, lk(0, 0, 6'd0, '0));
        issue(OP_LKP, '0, fk(100), '0, lk(1, 0, 6'd0, 38'd100));
        issue(OP_LKP, '0, fk(5), '0, lk(1, 0, 6'd5, 38'd5));
        idle(2);
        chk("hold_rsp_vld", rsp_vld, 1'b0);
        chk("hold_rsp_idx", rsp_idx, 6'd5);
        chk("hold_rsp_hit", rsp_hit, 1'b1);

        // Demap-all; a lookup is held on op_vld throughout and must be ignored.
        issue(OP_DALL, '0, '0, '0, nr());
        chk("sweep_rdy_low", op_rdy, 1'b0);
        n = 0;
        op_vld = 1'b1; op = OP_LKP; op_key = fk(5);
        while (!op_rdy && n < 100) begin n++; idle(1); end
        op_vld = 1'b0;
        chk("sweep_cycles", n, 8);
        chk("full_after_sweep", full, 1'b0);
        issue(OP_LKP, '0, fk(5), '0, lk(0, 0, 6'd0, '0));
        issue(OP_LKP, '0, fk(63), '0, lk(0, 0, 6'd0, '0));
        issue(OP_LKP, '0, fk(101), '0, lk(0, 0, 6'd0, '0));
        issue(OP_WRR, '0, fk(300), 38'd7, wr(6'd0));
        idle(2);
        chk("drain_fill", exp_q.size(), 0);

        // Reset during the third sweep cycle.
        for (int i = 0; i < 4; i++) issue(OP_WRI, IDX_W'(i), fk(200 + i), 38'd9, wr(IDX_W'(i)));
        issue(OP_DALL, '0, '0, '0, nr());
        idle(2);
        chk("midsweep_rdy_low", op_rdy, 1'b0);
        chk("midsweep_queue", exp_q.size(), 0);
        rst_l = 1'b0;
        #1;
        chk("abort_op_rdy", op_rdy, 1'b1);
        chk("abort_rsp_vld", rsp_vld, 1'b0);
        chk("abort_rsp_idx", rsp_idx, '0);
        chk("abort_full", full, 1'b0);
        idle(1);
        rst_l = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) issue(OP_LKP, '0, fk(200 + i), '0, lk(0, 0, 6'd0, '0));
        issue(OP_WRR, '0, fk(400), 38'd1, wr(6'd0));
        idle(2);
        chk("drain_abort", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/n2_tlb_param_cam.md
N2_TLB_PARAM_CAM -- requirements
Module: n2_tlb_param_cam

Interface
REQ-001 Parameter ENTRIES, default 64, number of entries (power of 2, 8..128); IDX_W = log2(ENTRIES).
REQ-002 Parameter KEY_W, default 66, stored tag width.
REQ-003 Parameter CTX_W, default 13, context field = key[CTX_W-1:0].
REQ-004 Parameter DATA_W, default 38, stored TTE data width.
REQ-005 l2clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_l  in  1  reset, asynchronous assert, active-low.
REQ-007 op_vld  in  1  operation request this cycle.
REQ-008 op  in  3  0 lookup, 1 write-indexed, 2 write-replace, 3 read, 4 demap-page, 5 demap-context, 6 demap-all, 7 reserved (no-op).
REQ-009 op_idx  in  IDX_W  entry index for ops 1 and 3.
REQ-010 op_key  in  KEY_W  lookup/write/demap key.
REQ-011 op_data  in  DATA_W  write data.
REQ-012 op_rdy  out  1  accepting ops.
REQ-013 rsp_vld  out  1  response valid, one cycle after accepted op 0-3.
REQ-014 rsp_hit, rsp_mhit  out  1 each  lookup hit / multiple hit.
REQ-015 rsp_idx  out  IDX_W  hit index (lowest hitting), written index, or read index.
REQ-016 rsp_key  out  KEY_W  read tag; rsp_data  out  DATA_W  hit/read data.
REQ-017 rsp_valid_bit  out  1  valid bit of read entry.
REQ-018 full  out  1  all entries valid.

Function
REQ-019 Op accepted when op_vld and op_rdy; op_rdy is 0 only during demap-all sweep.
REQ-020 Lookup: compare op_key with every valid entry; registered result next cycle: rsp_hit = any match, rsp_mhit = two or more, rsp_idx/rsp_data of lowest matching index; miss gives rsp_idx=0, rsp_data=0.
REQ-021 Write-indexed: entry op_idx gets key, data, valid=1, used=1; rsp_idx=op_idx next cycle.
REQ-022 Write-replace: victim = lowest invalid entry; if none, lowest entry with used=0; written as REQ-021; rsp_idx=victim.
REQ-023 Read: rsp_key, rsp_data, rsp_valid_bit of entry op_idx next cycle; no state change.
REQ-024 Used bits: set on lookup hit (all hitting entries) and on write; if this update would make all valid entries used, clear all used bits except those just set, same cycle.
REQ-025 Demap-page: clear valid of every entry whose key equals op_key, single cycle, no rsp_vld.
REQ-026 Demap-context: clear valid of every entry whose context field equals op_key context field, single cycle, no rsp_vld.
REQ-027 Demap-all: FSM IDLE->SWEEP; SWEEP clears valid and used of 8 entries per cycle from index 0 upward, op_rdy=0; after last group returns to IDLE, op_rdy=1 next cycle; duration ENTRIES/8 cycles.
REQ-028 Ops take effect at the accepting edge; an op in cycle N observes state written in cycle N-1 (lookup after write hits).
REQ-029 Op 7 and ops while op_rdy=0 are ignored, no rsp_vld.
REQ-030 rsp_* hold last value when rsp_vld=0.
REQ-031 full is combinational AND of valid bits.

Reset
REQ-032 rst_l low: all valid and used bits 0, FSM IDLE, op_rdy=1, rsp_vld=0, all rsp_* outputs 0, full=0; key/data arrays not reset.
REQ-033 Reset asserted mid-sweep aborts sweep; state per REQ-032 immediately.

Verification
REQ-034 Write-indexed idx 5 key K1 data D1, then lookup K1 -> rsp_hit=1, rsp_mhit=0, rsp_idx=5, rsp_data=D1.
REQ-035 Write-indexed idx 3 and idx 9 both key K2, lookup K2 -> rsp_hit=1, rsp_mhit=1, rsp_idx=3.
REQ-036 After reset, ENTRIES write-replace ops -> rsp_idx 0..ENTRIES-1 in order, full=1 after last; next write-replace -> rsp_idx of lowest entry with used=0 per REQ-024.
REQ-037 Fill 64 entries, demap-all -> op_rdy=0 for exactly 8 cycles, then lookup of any prior key misses, full=0.
REQ-038 Entries with context 0x001 at idx 0,2 and 0x002 at idx 1; demap-context 0x001 -> lookups hit only idx 1.
REQ-039 Reset asserted at sweep cycle 3 -> op_rdy=1, rsp_vld=0, all lookups miss after release.
